pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush/redirect scheduler for the RV64 in-order pipeline (IFP, IFR, IDC, IDR, EXA, EXB, MEM).
- Merges three hazard sources into per-stage stall and flush controls and the IFP redirect: data-memory waits, taken branches resolved in EXB, and load-use interlocks.
- Sequences the data-memory handshake.
- Discards instruction-memory responses orphaned by a redirect.
- Maintains two performance counters.

## Interface
Parameters:
- XLEN, 64, PC/target width
- RAW, 5, register index width
- CNT_W, 32, perf counter width
- MAX_OUT, 2, max outstanding imem requests

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset; asynchronous, active-low
- branch_taken_EXB  in  1  EXB resolved a taken branch/jump
- branch_target_EXB  in  XLEN  redirect PC
- load_EXA / load_EXB  in  1  instruction in that stage is a load
- rd_EXA / rd_EXB  in  RAW  destination register
- rs1_IDR / rs2_IDR  in  RAW  IDR source registers
- rs1_used_IDR / rs2_used_IDR  in  1  source actually read
- mem_req_MEM  in  1  MEM stage needs a data access
- dmem_ack  in  1  data memory completed the access
- dmem_req  out  1  data access request, level, held until ack
- imem_req_fire  in  1  IFP issued a fetch this cycle
- imem_rvalid  in  1  fetch response arrives this cycle
- imem_drop  out  1  discard this response
- stall_IFP … stall_MEM  out  1 each  hold stage register
- flush_IFR, flush_IDC, flush_IDR, flush_EXA  out  1 each  load bubble
- redirect_IFP  out  1  load redirect_target_IFP into PC
- redirect_target_IFP  out  XLEN  copy of branch_target_EXB
- stall_cycles, redirect_count  out  CNT_W each  perf counters

## Operation
- **Memory FSM (M_IDLE, M_WAIT, M_DONE)**
  - M_IDLE to M_WAIT when mem_req_MEM.
  - M_WAIT to M_DONE on dmem_ack.
  - M_DONE to M_IDLE unconditionally.
  - dmem_req = (state==M_WAIT).
  - mem_stall = (M_IDLE & mem_req_MEM) | M_WAIT.
  - M_DONE never stalls, so MEM advances exactly one cycle after the ack.
- **Priority:** mem_stall > branch > load-use.
- **mem_stall:** assert all of stall_IFP..stall_MEM. No flush and no redirect in that cycle. The branch is held in EXB and issues when the stall drops.
- **Branch:** redirect_IFP = branch_taken_EXB & ~mem_stall. This asserts flush_IFR/IDC/IDR/EXA and no stalls.
- **Load-use:** hazard when all of the following hold:
  - load_EXA or load_EXB is set;
  - the corresponding rd is nonzero;
  - rd equals a used rs1_IDR or rs2_IDR.
  
  Response:
  - assert stall_IFP..stall_IDR and flush_EXA;
  - EXB and MEM advance.
  
  Ignored when mem_stall or redirect is active.
- **Fetch tracker**
  - Holds an outstanding count: +imem_req_fire, −imem_rvalid, saturating at MAX_OUT.
  - Holds a drop_cnt.
  - On redirect: drop_cnt <= outstanding + imem_req_fire − imem_rvalid. This count includes a request fired in the redirect cycle.
  - imem_drop = imem_rvalid & (drop_cnt≠0). drop_cnt decrements per dropped response.
  - A redirect while drop_cnt≠0 recomputes drop_cnt from outstanding; drops are never double-counted.
- **Counters**
  - stall_cycles +1 on every cycle stall_IFP=1.
  - redirect_count +1 per redirect_IFP.
  - Both wrap modulo 2^CNT_W.

## Timing
- Flush, stall, redirect and imem_drop are combinational from the current inputs and state, in the same cycle.
- dmem_req is registered-state decoded.
- Minimum MEM occupancy for an access is 3 cycles: request, ack in the first M_WAIT cycle, then M_DONE.
- Reset (asynchronous, any cycle, including mid-M_WAIT):
  - state is M_IDLE;
  - outstanding, drop_cnt and both counters are 0;
  - all outputs are 0 and redirect_target_IFP is 0;
  - an in-flight dmem transaction is abandoned and the memory side owns recovery.
- Simultaneous imem_req_fire and imem_rvalid leave outstanding unchanged.
- imem_rvalid with outstanding=0 is illegal; the bench flags it with an assertion.

## Structure
- pipeline_pkg holds:
  - mem_state_t enum;
  - XLEN/RAW defaults;
  - pipe_ctrl_t struct bundling the stall/flush vectors.
- One sub-module, pipe_fetch_tracker, holds the outstanding and drop_cnt logic.
- FSM, priority decode and counters stay in pipe_ctrl.

## Test plan
- **Data access:** mem_req_MEM=1, ack on the 3rd M_WAIT cycle -> stall_MEM high for 4 cycles; dmem_req high 3 cycles; M_DONE cycle has no stall; stall_cycles=4.
- **Branch:** branch_taken_EXB=1, target 0x8000_0040, no other hazards -> same cycle redirect_IFP=1, four flushes=1, target 0x8000_0040, redirect_count=1.
- **Branch under mem stall:** branch during mem_stall with ack after 2 cycles -> no redirect while stalled; exactly one redirect in the M_DONE cycle.
- **Load-use:**
  - load_EXA, rd_EXA=5, rs2_IDR=5, rs2_used=1 -> stall_IFP..IDR and flush_EXA, EXB not stalled.
  - Same case with rd_EXA=0 -> no hazard.
  - Same case with a concurrent branch -> branch wins.
- **Orphaned fetches:** two imem_req_fire, then redirect before any response -> next two imem_rvalid give imem_drop=1, the third gives 0.
- **Reset mid-operation:** assert rst_n=0 in M_WAIT with drop_cnt=1 -> immediately all outputs 0; after release, a new mem_req_MEM starts from M_IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the RV64 pipeline control block:
// memory FSM states and the bundled stall/flush controls.
package pipeline_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RAW_DEF  = 5;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_DONE
    } mem_state_t;

    // stall[6]=IFP .. stall[0]=MEM, flush[3]=IFR .. flush[0]=EXA
    typedef struct packed {
        logic [6:0] stall;
        logic [3:0] flush;
        logic       redirect;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipe_fetch_tracker.sv
// Tracks outstanding instruction fetches and counts the responses
// that must be discarded after a redirect.
module pipe_fetch_tracker #(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic redirect,
    input  logic imem_req_fire,
    input  logic imem_rvalid,
    output logic imem_drop
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);

    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_next;
    logic [OW-1:0] drop_cnt;

    always_comb begin
        out_next = outstanding;
        if (imem_req_fire && !imem_rvalid && outstanding != OUT_MAX)
            out_next = outstanding + 1'b1;
        else if (!imem_req_fire && imem_rvalid && outstanding != '0)
            out_next = outstanding - 1'b1;
    end

    assign imem_drop = rst_n && imem_rvalid && (drop_cnt != '0);

    // A redirect reloads drop_cnt from the live count, so an earlier
    // pending drop is never counted twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect)
                drop_cnt <= out_next;
            else if (imem_drop)
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect scheduler for the seven-stage RV64 pipeline,
// with data-memory handshake sequencing and perf counters.
module pipe_ctrl
    import pipeline_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RAW     = RAW_DEF,
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken_EXB,
    input  logic [XLEN-1:0]  branch_target_EXB,
    input  logic             load_EXA,
    input  logic             load_EXB,
    input  logic [RAW-1:0]   rd_EXA,
    input  logic [RAW-1:0]   rd_EXB,
    input  logic [RAW-1:0]   rs1_IDR,
    input  logic [RAW-1:0]   rs2_IDR,
    input  logic             rs1_used_IDR,
    input  logic             rs2_used_IDR,
    input  logic             mem_req_MEM,
    input  logic             dmem_ack,
    output logic             dmem_req,
    input  logic             imem_req_fire,
    input  logic             imem_rvalid,
    output logic             imem_drop,
    output logic             stall_IFP,
    output logic             stall_IFR,
    output logic             stall_IDC,
    output logic             stall_IDR,
    output logic             stall_EXA,
    output logic             stall_EXB,
    output logic             stall_MEM,
    output logic             flush_IFR,
    output logic             flush_IDC,
    output logic             flush_IDR,
    output logic             flush_EXA,
    output logic             redirect_IFP,
    output logic [XLEN-1:0]  redirect_target_IFP,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    mem_state_t state;
    pipe_ctrl_t ctrl;
    logic       mem_stall;
    logic       br;
    logic       lu;
    logic       hit_a;
    logic       hit_b;

    assign hit_a = load_EXA && rd_EXA != '0 &&
                   ((rs1_used_IDR && rs1_IDR == rd_EXA) ||
                    (rs2_used_IDR && rs2_IDR == rd_EXA));
    assign hit_b = load_EXB && rd_EXB != '0 &&
                   ((rs1_used_IDR && rs1_IDR == rd_EXB) ||
                    (rs2_used_IDR && rs2_IDR == rd_EXB));

    // Gating with rst_n keeps every control low while reset is held.
    assign mem_stall = rst_n &&
                       ((state == M_IDLE && mem_req_MEM) || state == M_WAIT);
    assign br = rst_n && branch_taken_EXB && !mem_stall;
    assign lu = rst_n && (hit_a || hit_b) && !mem_stall && !br;

    always_comb begin
        ctrl = CTRL_NONE;
        unique case (1'b1)
            mem_stall: ctrl.stall = '1;
            br: begin
                ctrl.flush    = '1;
                ctrl.redirect = 1'b1;
            end
            lu: begin
                ctrl.stall = 7'b111_1000;
                ctrl.flush = 4'b0001;
            end
            default: ;
        endcase
    end

    assign {stall_IFP, stall_IFR, stall_IDC, stall_IDR,
            stall_EXA, stall_EXB, stall_MEM} = ctrl.stall;
    assign {flush_IFR, flush_IDC, flush_IDR, flush_EXA} = ctrl.flush;
    assign redirect_IFP        = ctrl.redirect;
    assign redirect_target_IFP = rst_n ? branch_target_EXB : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= M_IDLE;
            dmem_req <= 1'b0;
        end else begin
            unique case (state)
                M_IDLE: if (mem_req_MEM) begin
                    state    <= M_WAIT;
                    dmem_req <= 1'b1;
                end
                M_WAIT: if (dmem_ack) begin
                    state    <= M_DONE;
                    dmem_req <= 1'b0;
                end
                M_DONE: begin
                    state    <= M_IDLE;
                    dmem_req <= 1'b0;
                end
                default: begin
                    state    <= M_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (stall_IFP)
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect_IFP)
                redirect_count <= redirect_count + 1'b1;
        end
    end

    pipe_fetch_tracker #(
        .MAX_OUT(MAX_OUT)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect_IFP),
        .imem_req_fire(imem_req_fire),
        .imem_rvalid  (imem_rvalid),
        .imem_drop    (imem_drop)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected control vectors
// are queued with the stimulus and compared when the outputs settle.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [6:0] stall;
        logic [3:0] flush;
        logic       redir;
        logic       drop;
        logic       dreq;
    } vec_t;

    localparam vec_t V_NONE = '0;
    localparam vec_t V_MEM  = {7'h7F, 4'h0, 3'b000};
    localparam vec_t V_MEMW = {7'h7F, 4'h0, 3'b001};
    localparam vec_t V_BR   = {7'h00, 4'hF, 3'b100};
    localparam vec_t V_LU   = {7'h78, 4'h1, 3'b000};
    localparam vec_t V_DROP = {7'h00, 4'h0, 3'b010};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken_EXB;
    logic [63:0] branch_target_EXB;
    logic        load_EXA, load_EXB;
    logic [4:0]  rd_EXA, rd_EXB, rs1_IDR, rs2_IDR;
    logic        rs1_used_IDR, rs2_used_IDR;
    logic        mem_req_MEM, dmem_ack, dmem_req;
    logic        imem_req_fire, imem_rvalid, imem_drop;
    logic        stall_IFP, stall_IFR, stall_IDC, stall_IDR;
    logic        stall_EXA, stall_EXB, stall_MEM;
    logic        flush_IFR, flush_IDC, flush_IDR, flush_EXA;
    logic        redirect_IFP;
    logic [63:0] redirect_target_IFP;
    logic [31:0] stall_cycles, redirect_count;

    vec_t obs;
    vec_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_sc = 0;
    int   exp_rc = 0;
    int   m_out = 0;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken_EXB(branch_taken_EXB),
        .branch_target_EXB(branch_target_EXB),
        .load_EXA(load_EXA), .load_EXB(load_EXB),
        .rd_EXA(rd_EXA), .rd_EXB(rd_EXB),
        .rs1_IDR(rs1_IDR), .rs2_IDR(rs2_IDR),
        .rs1_used_IDR(rs1_used_IDR), .rs2_used_IDR(rs2_used_IDR),
        .mem_req_MEM(mem_req_MEM), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req),
        .imem_req_fire(imem_req_fire), .imem_rvalid(imem_rvalid),
        .imem_drop(imem_drop),
        .stall_IFP(stall_IFP), .stall_IFR(stall_IFR),
        .stall_IDC(stall_IDC), .stall_IDR(stall_IDR),
        .stall_EXA(stall_EXA), .stall_EXB(stall_EXB),
        .stall_MEM(stall_MEM),
        .flush_IFR(flush_IFR), .flush_IDC(flush_IDC),
        .flush_IDR(flush_IDR), .flush_EXA(flush_EXA),
        .redirect_IFP(redirect_IFP),
        .redirect_target_IFP(redirect_target_IFP),
        .stall_cycles(stall_cycles),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    assign obs = {stall_IFP, stall_IFR, stall_IDC, stall_IDR,
                  stall_EXA, stall_EXB, stall_MEM,
                  flush_IFR, flush_IDC, flush_IDR, flush_EXA,
                  redirect_IFP, imem_drop, dmem_req};

    // Reference outstanding-fetch count for the protocol assertion.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= 0;
        end else begin
            assert (!(imem_rvalid && m_out == 0))
                else $error("FAIL imem_rvalid with nothing outstanding");
            if (imem_req_fire && !imem_rvalid && m_out < 2)
                m_out <= m_out + 1;
            else if (!imem_req_fire && imem_rvalid && m_out > 0)
                m_out <= m_out - 1;
        end
    end

    task automatic idle();
        branch_taken_EXB  = 1'b0;
        branch_target_EXB = '0;
        load_EXA = 1'b0; load_EXB = 1'b0;
        rd_EXA = '0; rd_EXB = '0; rs1_IDR = '0; rs2_IDR = '0;
        rs1_used_IDR = 1'b0; rs2_used_IDR = 1'b0;
        mem_req_MEM = 1'b0; dmem_ack = 1'b0;
        imem_req_fire = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        mem_req_MEM = 1'b1; branch_taken_EXB = 1'b1;
        branch_target_EXB = 64'h1234;
        load_EXA = 1'b1; rd_EXA = 5'd5; rs1_IDR = 5'd5; rs1_used_IDR = 1'b1;
        q.push_back(V_NONE);
        #3;
        begin
            vec_t g = q.pop_front();
            n_vec++;
            if (obs !== g) begin
                n_bad++;
                $display("FAIL reset_ctrl: got %b required %b", obs, g);
            end
        end
        n_vec++;
        if (redirect_target_IFP !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_target: got %h required 0", redirect_target_IFP);
        end
        n_vec++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0",
                     stall_cycles, redirect_count);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_data_access();
        for (int c = 0; c < 6; c++) begin
            vec_t e;
            idle();
            mem_req_MEM = (c < 5);
            dmem_ack    = (c == 3);
            e = (c == 0) ? V_MEM : (c <= 3) ? V_MEMW : V_NONE;
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL data_access c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== 32'(exp_sc)) begin
            n_bad++;
            $display("FAIL data_stall_cycles: got %0d required %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 2; c++) begin
            idle();
            branch_taken_EXB  = (c == 0);
            branch_target_EXB = 64'h8000_0040;
            q.push_back((c == 0) ? V_BR : V_NONE);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL branch c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            if (c == 0) begin
                n_vec++;
                if (redirect_target_IFP !== 64'h8000_0040) begin
                    n_bad++;
                    $display("FAIL branch_target: got %h required 80000040",
                             redirect_target_IFP);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (redirect_count !== 32'(exp_rc) || exp_rc != 1) begin
            n_bad++;
            $display("FAIL branch_count: got %0d required 1", redirect_count);
        end
    endtask

    task automatic test_branch_under_stall();
        int rc0 = exp_rc;
        for (int c = 0; c < 5; c++) begin
            vec_t e;
            idle();
            mem_req_MEM       = (c < 4);
            branch_taken_EXB  = (c < 4);
            branch_target_EXB = 64'h0000_1000;
            dmem_ack          = (c == 2);
            e = (c == 0) ? V_MEM : (c <= 2) ? V_MEMW : (c == 3) ? V_BR : V_NONE;
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL br_under_stall c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (redirect_count !== 32'(exp_rc) || exp_rc != rc0 + 1) begin
            n_bad++;
            $display("FAIL br_under_stall_count: got %0d required %0d",
                     redirect_count, rc0 + 1);
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 7; c++) begin
            vec_t e;
            idle();
            unique case (c)
                0: begin
                    load_EXA = 1; rd_EXA = 5; rs2_IDR = 5; rs2_used_IDR = 1;
                    e = V_LU;
                end
                1: begin
                    load_EXA = 1; rd_EXA = 0; rs2_IDR = 0; rs2_used_IDR = 1;
                    e = V_NONE;
                end
                2: begin
                    load_EXA = 1; rd_EXA = 5; rs2_IDR = 5; rs2_used_IDR = 1;
                    branch_taken_EXB = 1; branch_target_EXB = 64'h200;
                    e = V_BR;
                end
                3: begin
                    load_EXB = 1; rd_EXB = 7; rs1_IDR = 7; rs1_used_IDR = 1;
                    e = V_LU;
                end
                4: begin
                    load_EXB = 1; rd_EXB = 7; rs1_IDR = 7; rs1_used_IDR = 0;
                    e = V_NONE;
                end
                5: begin
                    rd_EXA = 5; rs2_IDR = 5; rs2_used_IDR = 1;
                    e = V_NONE;
                end
                default: e = V_NONE;
            endcase
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL load_use c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== 32'(exp_sc)) begin
            n_bad++;
            $display("FAIL load_use_stall_cycles: got %0d required %0d",
                     stall_cycles, exp_sc);
        end
    endtask

    task automatic test_orphaned_fetch();
        for (int c = 0; c < 8; c++) begin
            vec_t e;
            idle();
            imem_req_fire    = (c == 0 || c == 1 || c == 5);
            branch_taken_EXB = (c == 2);
            imem_rvalid      = (c == 3 || c == 4 || c == 6);
            e = (c == 2) ? V_BR : (c == 3 || c == 4) ? V_DROP : V_NONE;
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL orphan c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (redirect_count !== 32'(exp_rc)) begin
            n_bad++;
            $display("FAIL orphan_count: got %0d required %0d", redirect_count, exp_rc);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            vec_t e;
            idle();
            mem_req_MEM = (c < 6);
            dmem_ack    = (c == 1 || c == 4);
            unique case (c)
                0, 3:    e = V_MEM;
                1, 4:    e = V_MEMW;
                default: e = V_NONE;
            endcase
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL back_to_back c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== 32'(exp_sc)) begin
            n_bad++;
            $display("FAIL b2b_stall_cycles: got %0d required %0d", stall_cycles, exp_sc);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            vec_t e;
            idle();
            imem_req_fire    = (c == 0);
            branch_taken_EXB = (c == 1);
            mem_req_MEM      = (c >= 2);
            imem_rvalid      = (c == 3);
            unique case (c)
                1:       e = V_BR;
                2:       e = V_MEM;
                3:       e = {7'h7F, 4'h0, 3'b011};
                default: e = V_NONE;
            endcase
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL reset_mid_pre c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            if (c < 3) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        exp_sc = 0;
        exp_rc = 0;
        q.push_back(V_NONE);
        #1;
        begin
            vec_t g = q.pop_front();
            n_vec++;
            if (obs !== g) begin
                n_bad++;
                $display("FAIL reset_mid_ctrl: got %b required %b", obs, g);
            end
        end
        n_vec++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_counters: got %0d/%0d required 0/0",
                     stall_cycles, redirect_count);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            vec_t e;
            idle();
            mem_req_MEM   = (c < 3);
            dmem_ack      = (c == 1);
            imem_req_fire = (c == 3);
            imem_rvalid   = (c == 4);
            e = (c == 0) ? V_MEM : (c == 1) ? V_MEMW : V_NONE;
            q.push_back(e);
            #2;
            begin
                vec_t g = q.pop_front();
                n_vec++;
                if (obs !== g) begin
                    n_bad++;
                    $display("FAIL reset_mid_post c%0d: got %b required %b", c, obs, g);
                end
                exp_sc += int'(g.stall[6]);
                exp_rc += int'(g.redir);
            end
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== 32'(exp_sc) || redirect_count !== 32'(exp_rc)) begin
            n_bad++;
            $display("FAIL reset_mid_post_counters: got %0d/%0d required %0d/%0d",
                     stall_cycles, redirect_count, exp_sc, exp_rc);
        end
    endtask

    initial begin
        test_reset();
        test_data_access();
        test_branch();
        test_branch_under_stall();
        test_load_use();
        test_orphaned_fetch();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
